// File: rtl/prim_fifo_n.sv
// First-word fall-through FIFO with upstream/downstream valid-ready handshakes,
// a downstream stall mask, synchronous flush and occupancy flags.
module prim_fifo_n #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         urdy_o,
  input  logic                         uvld_i,
  input  logic [WIDTH-1:0]             udat_i,
  input  logic                         dstall_i,
  input  logic                         drdy_i,
  output logic                         dvld_o,
  output logic [WIDTH-1:0]             ddat_o,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         afull_o,
  output logic                         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             push;
  logic             pop;

  // Flags come straight from the registered count, so urdy_o has no path from the downstream side.
  assign urdy_o  = (count_reg != CW'(DEPTH));
  assign empty_o = (count_reg == '0);
  assign afull_o = (count_reg >= CW'(AFULL_LVL));
  assign count_o = count_reg;

  assign dvld_o  = !empty_o && !dstall_i;
  assign push    = uvld_i && urdy_o;
  assign pop     = dvld_o && drdy_i;

  // Head entry is read asynchronously to give fall-through with one cycle write-to-read latency.
  assign ddat_o  = mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  // Storage needs no reset; a stray write during flush/reset lands in a slot treated as empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= udat_i;
  end

endmodule

// File: tb/tb_prim_fifo_n.sv
// Scoreboard bench for prim_fifo_n (WIDTH=8, DEPTH=4, AFULL_LVL=3): directed
// fill/drain/stream/stall/flush/reset sequences followed by random traffic.
module tb_prim_fifo_n;

  logic       clk;
  logic       reset;
  logic       urdy;
  logic       uvld;
  logic [7:0] udat;
  logic       dstall;
  logic       drdy;
  logic       dvld;
  logic [7:0] ddat;
  logic       flush;
  logic [2:0] count;
  logic       afull;
  logic       empty;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb_q[$];

  prim_fifo_n #(.WIDTH(8), .DEPTH(4), .AFULL_LVL(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .urdy_o   (urdy),
    .uvld_i   (uvld),
    .udat_i   (udat),
    .dstall_i (dstall),
    .drdy_i   (drdy),
    .dvld_o   (dvld),
    .ddat_o   (ddat),
    .flush_i  (flush),
    .count_o  (count),
    .afull_o  (afull),
    .empty_o  (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act_v, exp_v, $time);
    end
  endtask

  // Drives one cycle of stimulus, checks outputs against the scoreboard, then advances the model.
  task automatic step(input logic v, input logic [7:0] d, input logic rdy,
                      input logic stl, input logic fl, input logic rst_n);
    int   n;
    logic e_dvld;
    logic e_push;
    logic e_pop;
    uvld = v; udat = d; drdy = rdy; dstall = stl; flush = fl; reset = rst_n;
    #1;
    n      = sb_q.size();
    e_dvld = (n != 0) && !stl;
    check_eq("dvld",  32'(dvld),  32'(e_dvld));
    check_eq("urdy",  32'(urdy),  32'(n != 4));
    check_eq("count", 32'(count), 32'(n));
    check_eq("afull", 32'(afull), 32'(n >= 3));
    check_eq("empty", 32'(empty), 32'(n == 0));
    if (e_dvld) check_eq("ddat", 32'(ddat), 32'(sb_q[0]));
    e_push = v && (n != 4);
    e_pop  = e_dvld && rdy;
    if (!rst_n || fl) begin
      $display("%s: %0d entries discarded", !rst_n ? "reset" : "flush", n);
      sb_q.delete();
    end else begin
      if (e_pop) begin
        $display("pop  0x%02h", sb_q[0]);
        void'(sb_q.pop_front());
      end
      if (e_push) begin
        $display("push 0x%02h", d);
        sb_q.push_back(d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] fill_dat [5];
    fill_dat[0] = 8'h11; fill_dat[1] = 8'h22; fill_dat[2] = 8'h33;
    fill_dat[3] = 8'h44; fill_dat[4] = 8'h55;

    uvld = 0; udat = 0; drdy = 0; dstall = 0; flush = 0; reset = 0;
    @(posedge clk);
    #1;

    // Reset state, then fill past full (0x55 must be ignored).
    step(0, 8'h00, 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, fill_dat[i], 0, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0, 1);

    // Drain from full.
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0, 1);
    step(0, 8'h00, 1, 0, 0, 1);

    // Streaming push+pop with wrap-around.
    for (int i = 0; i < 10; i++) step(1, 8'(i), 1, 0, 0, 1);
    step(0, 8'h00, 1, 0, 0, 1);
    step(0, 8'h00, 1, 0, 0, 1);

    // Stall holds contents regardless of drdy.
    step(1, 8'h11, 0, 0, 0, 1);
    step(1, 8'h22, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0, 1);

    // Flush with a same-cycle push of 0x99.
    for (int i = 0; i < 3; i++) step(1, fill_dat[i], 0, 0, 0, 1);
    step(1, 8'h99, 1, 0, 1, 1);
    step(0, 8'h00, 1, 0, 0, 1);
    step(0, 8'h00, 1, 0, 0, 1);

    // Reset mid-operation at count 2.
    step(1, 8'hA1, 0, 0, 0, 1);
    step(1, 8'hA2, 0, 0, 0, 1);
    step(1, 8'hA3, 1, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0, 1);

    // Random traffic with rare flush and reset.
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 40) == 0),
           1'($urandom_range(0, 60) != 0));
    end
    step(0, 8'h00, 1, 0, 1, 1);
    step(0, 8'h00, 1, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
